// File: rtl/fft_bfly_seq.sv
// fft_bfly_seq: switch-driven radix-2 FFT butterfly, y = a + W^k*b, z = a - W^k*b
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   sw_enable  : run enable, low returns to IDLE
//   sw_step    : operator step, rising edge advances the sequence
//   sw_data    : operand entry (two's complement), [2:0] = twiddle index in LOAD_TW
//   led        : displayed value (live sw_data while loading, results while showing)
//   state_code : current state encoding
//   ovf        : any of the four sums left the DATA_W signed range
// Define FFT_BFLY_SAT_EN to saturate the sums instead of wrapping them.
module fft_bfly_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sw_enable,
    input  logic              sw_step,
    input  logic [DATA_W-1:0] sw_data,
    output logic [DATA_W-1:0] led,
    output logic [3:0]        state_code,
    output logic              ovf
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_TW  = 4'd1;
    localparam logic [3:0] S_LOAD_REB = 4'd2;
    localparam logic [3:0] S_LOAD_IMB = 4'd3;
    localparam logic [3:0] S_LOAD_REA = 4'd4;
    localparam logic [3:0] S_LOAD_IMA = 4'd5;
    localparam logic [3:0] S_COMPUTE  = 4'd6;
    localparam logic [3:0] S_SHOW_REY = 4'd7;
    localparam logic [3:0] S_SHOW_IMY = 4'd8;
    localparam logic [3:0] S_SHOW_REZ = 4'd9;
    localparam logic [3:0] S_SHOW_IMZ = 4'd10;
    localparam logic signed [DATA_W-1:0] W_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] W_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] W_ZERO = '0;
    // round(0.70711 * 2^(DATA_W-1)) in integer arithmetic
    localparam longint C_L = ((longint'(70711) << (DATA_W-1)) + 50000) / 100000;
    localparam logic signed [DATA_W-1:0] W_C  = DATA_W'(C_L);
    localparam logic signed [DATA_W-1:0] W_NC = DATA_W'(-C_L);

    logic [3:0]               state_q, state_d;
    logic                     step_q, step_d, step_edge;
    logic [2:0]               tw_q, tw_d;
    logic signed [DATA_W-1:0] reb_q, reb_d, imb_q, imb_d, rea_q, rea_d, ima_q, ima_d;
    logic [DATA_W-1:0]        rey_q, rey_d, imy_q, imy_d, rez_q, rez_d, imz_q, imz_d;
    logic                     ovf_q, ovf_d;
    logic signed [DATA_W-1:0] rew, imw;
    logic signed [2*DATA_W:0] pr, pi;
    logic signed [DATA_W+1:0] wr, wi, s_rey, s_imy, s_rez, s_imz;
    logic                     any_oor;

    function automatic logic signed [2*DATA_W:0] sx(input logic signed [DATA_W-1:0] v);
        return {{(DATA_W+1){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [DATA_W+1:0] ex2(input logic signed [DATA_W-1:0] v);
        return {{2{v[DATA_W-1]}}, v};
    endfunction

    // out of range when the top three bits are not a pure sign extension
    function automatic logic oor(input logic signed [DATA_W+1:0] s);
        return !(&s[DATA_W+1:DATA_W-1]) && (|s[DATA_W+1:DATA_W-1]);
    endfunction

    function automatic logic [DATA_W-1:0] fit(input logic signed [DATA_W+1:0] s);
`ifdef FFT_BFLY_SAT_EN
        return oor(s) ? (s[DATA_W+1] ? W_MIN : W_MAX) : s[DATA_W-1:0];
`else
        return s[DATA_W-1:0];
`endif
    endfunction

    // W^k = exp(-j*2*pi*k/8)
    always_comb begin
        rew = W_MAX;
        imw = W_ZERO;
        case (tw_q)
            3'd1:    begin rew = W_C;    imw = W_NC;   end
            3'd2:    begin rew = W_ZERO; imw = W_MIN;  end
            3'd3:    begin rew = W_NC;   imw = W_NC;   end
            3'd4:    begin rew = W_MIN;  imw = W_ZERO; end
            3'd5:    begin rew = W_NC;   imw = W_C;    end
            3'd6:    begin rew = W_ZERO; imw = W_MAX;  end
            3'd7:    begin rew = W_C;    imw = W_C;    end
            default: begin rew = W_MAX;  imw = W_ZERO; end
        endcase
    end

    always_comb begin
        pr = sx(rew) * sx(reb_q) - sx(imw) * sx(imb_q);
        pi = sx(rew) * sx(imb_q) + sx(imw) * sx(reb_q);
        wr = (DATA_W+2)'(pr >>> (DATA_W-1));
        wi = (DATA_W+2)'(pi >>> (DATA_W-1));
        s_rey = ex2(rea_q) + wr;
        s_imy = ex2(ima_q) + wi;
        s_rez = ex2(rea_q) - wr;
        s_imz = ex2(ima_q) - wi;
        any_oor = oor(s_rey) | oor(s_imy) | oor(s_rez) | oor(s_imz);
    end

    always_comb begin
        step_d = sw_step;
        step_edge = sw_step & ~step_q;
        state_d = state_q;
        tw_d = tw_q;
        reb_d = reb_q;
        imb_d = imb_q;
        rea_d = rea_q;
        ima_d = ima_q;
        rey_d = rey_q;
        imy_d = imy_q;
        rez_d = rez_q;
        imz_d = imz_q;
        ovf_d = ovf_q;
        if (!sw_enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (step_edge) state_d = S_LOAD_TW;
                S_LOAD_TW:  if (step_edge) begin tw_d  = sw_data[2:0]; state_d = S_LOAD_REB; end
                S_LOAD_REB: if (step_edge) begin reb_d = sw_data;      state_d = S_LOAD_IMB; end
                S_LOAD_IMB: if (step_edge) begin imb_d = sw_data;      state_d = S_LOAD_REA; end
                S_LOAD_REA: if (step_edge) begin rea_d = sw_data;      state_d = S_LOAD_IMA; end
                S_LOAD_IMA: if (step_edge) begin ima_d = sw_data;      state_d = S_COMPUTE;  end
                S_COMPUTE: begin
                    rey_d = fit(s_rey);
                    imy_d = fit(s_imy);
                    rez_d = fit(s_rez);
                    imz_d = fit(s_imz);
                    ovf_d = ovf_q | any_oor;
                    state_d = S_SHOW_REY;
                end
                S_SHOW_REY, S_SHOW_IMY, S_SHOW_REZ: if (step_edge) state_d = state_q + 4'd1;
                S_SHOW_IMZ: if (step_edge) state_d = S_LOAD_TW;
                default:    state_d = S_IDLE;
            endcase
        end
        if (state_d == S_LOAD_TW && state_q != S_LOAD_TW) ovf_d = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= 1'b1;
            tw_q    <= '0;
            reb_q   <= '0;
            imb_q   <= '0;
            rea_q   <= '0;
            ima_q   <= '0;
            rey_q   <= '0;
            imy_q   <= '0;
            rez_q   <= '0;
            imz_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tw_q    <= tw_d;
            reb_q   <= reb_d;
            imb_q   <= imb_d;
            rea_q   <= rea_d;
            ima_q   <= ima_d;
            rey_q   <= rey_d;
            imy_q   <= imy_d;
            rez_q   <= rez_d;
            imz_q   <= imz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        led = (state_q >= S_LOAD_TW && state_q <= S_LOAD_IMA) ? sw_data :
              (state_q == S_SHOW_REY) ? rey_q :
              (state_q == S_SHOW_IMY) ? imy_q :
              (state_q == S_SHOW_REZ) ? rez_q :
              (state_q == S_SHOW_IMZ) ? imz_q : '0;
        state_code = state_q;
        ovf = ovf_q;
    end
endmodule

// File: tb/tb_fft_bfly_seq.sv
// tb_fft_bfly_seq: directed and randomized bench for fft_bfly_seq against a sequence-level model
module tb_fft_bfly_seq;
    localparam int W = 8;
    logic         clock = 1'b0, reset = 1'b1, sw_enable = 1'b0, sw_step = 1'b0;
    logic [W-1:0] sw_data = '0;
    logic [W-1:0] led;
    logic [3:0]   state_code;
    logic         ovf;

    fft_bfly_seq #(.DATA_W(W)) dut (
        .clock(clock), .reset(reset), .sw_enable(sw_enable), .sw_step(sw_step),
        .sw_data(sw_data), .led(led), .state_code(state_code), .ovf(ovf)
    );

    always #5 clock = ~clock;

    real tw_re_r [8] = '{1.0, 0.70711, 0.0, -0.70711, -1.0, -0.70711, 0.0, 0.70711};
    real tw_im_r [8] = '{0.0, -0.70711, -1.0, -0.70711, 0.0, 0.70711, 1.0, 0.70711};
    int  tw_re [8];
    int  tw_im [8];
    int  m_pos, m_step, m_tw, m_ovf, m_e, m_wr, m_wi;
    int  m_op [4];
    int  m_res [4];
    int  m_s [4];
    int  n_pass = 0, n_total = 0;
    bit  chk_on = 0;
    bit  lit_valid = 0;
    int  lit_sel, lit_exp, exp_led, act;
    string lit_name;

    function automatic int q(input real x);
        int r;
        r = int'(x * 128.0);
        return r > 127 ? 127 : (r < -128 ? -128 : r);
    endfunction

    function automatic int red(input int s);
        int v;
`ifdef FFT_BFLY_SAT_EN
        return s > 127 ? 127 : (s < -128 ? -128 : s);
`else
        v = s & 255;
        return v > 127 ? v - 256 : v;
`endif
    endfunction

    initial for (int k = 0; k < 8; k++) begin
        tw_re[k] = q(tw_re_r[k]);
        tw_im[k] = q(tw_im_r[k]);
    end

    // sequence model: position 0 idle, 1..5 operand entry, 6 compute, 7..10 result display
    always @(posedge clock) begin
        m_e = (sw_step && m_step == 0) ? 1 : 0;
        if (reset) begin
            m_pos = 0; m_step = 1; m_tw = 0; m_ovf = 0;
            for (int k = 0; k < 4; k++) begin m_op[k] = 0; m_res[k] = 0; end
        end else begin
            m_step = sw_step ? 1 : 0;
            if (!sw_enable) m_pos = 0;
            else if (m_pos == 6) begin
                m_wr = (tw_re[m_tw] * m_op[0] - tw_im[m_tw] * m_op[1]) >>> 7;
                m_wi = (tw_re[m_tw] * m_op[1] + tw_im[m_tw] * m_op[0]) >>> 7;
                m_s[0] = m_op[2] + m_wr;
                m_s[1] = m_op[3] + m_wi;
                m_s[2] = m_op[2] - m_wr;
                m_s[3] = m_op[3] - m_wi;
                for (int k = 0; k < 4; k++) begin
                    if (m_s[k] > 127 || m_s[k] < -128) m_ovf = 1;
                    m_res[k] = red(m_s[k]);
                end
                m_pos = 7;
            end else if (m_e != 0) begin
                if (m_pos == 1) m_tw = int'(sw_data[2:0]);
                else if (m_pos >= 2 && m_pos <= 5) m_op[m_pos-2] = int'($signed(sw_data));
                m_pos = (m_pos == 10) ? 1 : m_pos + 1;
                if (m_pos == 1) m_ovf = 0;
            end
        end
    end

    always @(negedge clock) if (chk_on) begin
        exp_led = (m_pos >= 1 && m_pos <= 5) ? int'($signed(sw_data)) : (m_pos >= 7 ? m_res[m_pos-7] : 0);
        n_total++;
        if (led !== exp_led[W-1:0] || state_code !== m_pos[3:0] || ovf !== m_ovf[0])
            $display("FAIL cycle t=%0t: led=%0d state=%0d ovf=%0b, required led=%0d state=%0d ovf=%0d",
                     $time, $signed(led), state_code, ovf, exp_led, m_pos, m_ovf);
        else n_pass++;
        if (lit_valid) begin
            n_total++;
            act = lit_sel == 0 ? int'(state_code) : (lit_sel == 1 ? int'($signed(led)) : int'(ovf));
            if (act != lit_exp) $display("FAIL %s: got %0d, required %0d", lit_name, act, lit_exp);
            else n_pass++;
        end
    end

    task automatic tick(input logic r, input logic en, input logic st, input logic [W-1:0] d);
        @(posedge clock);
        #2;
        reset = r; sw_enable = en; sw_step = st; sw_data = d;
    endtask

    task automatic press(input logic [W-1:0] d);
        tick(0, 1, 1, d);
        tick(0, 1, 0, d);
    endtask

    task automatic expect_lit(input int sel, input int e, input string nm);
        lit_sel = sel; lit_exp = e; lit_name = nm; lit_valid = 1;
        @(negedge clock);
        #1;
        lit_valid = 0;
    endtask

    initial begin
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk_on = 1;
        tick(0, 1, 0, 0);
        expect_lit(0, 0, "reset_state");
        expect_lit(1, 0, "reset_led");
        expect_lit(2, 0, "reset_ovf");
        // W^0: b=20, a=10
        press(0); press(0); press(8'd20); press(0); press(8'd10); press(0);
        expect_lit(0, 6, "w0_compute_state");
        tick(0, 1, 0, 0);
        expect_lit(1, 29, "w0_rey");
        expect_lit(2, 0, "w0_ovf");
        press(0); expect_lit(1, 0, "w0_imy");
        press(0); expect_lit(1, -9, "w0_rez");
        press(0); expect_lit(1, 0, "w0_imz");
        press(0); expect_lit(0, 1, "w0_back_to_tw");
        // W^2: b=20, a=10+5j
        press(8'd2); press(8'd20); press(0); press(8'd10); press(8'd5);
        tick(0, 1, 0, 0);
        expect_lit(1, 10, "w2_rey"); expect_lit(0, 7, "w2_state7");
        press(0); expect_lit(1, -15, "w2_imy"); expect_lit(0, 8, "w2_state8");
        press(0); expect_lit(1, 10, "w2_rez"); expect_lit(0, 9, "w2_state9");
        press(0); expect_lit(1, 25, "w2_imz"); expect_lit(0, 10, "w2_state10");
        press(0); expect_lit(0, 1, "w2_state1");
        // W^4 overflow: b=-100, a=100
        press(8'd4); press(8'h9C); press(0); press(8'd100); press(0);
        tick(0, 1, 0, 0);
`ifdef FFT_BFLY_SAT_EN
        expect_lit(1, 127, "ovf_rey_sat");
`else
        expect_lit(1, -56, "ovf_rey_wrap");
`endif
        expect_lit(2, 1, "ovf_set");
        press(0); press(0); expect_lit(1, 0, "ovf_rez");
        press(0); press(0);
        expect_lit(0, 1, "ovf_reload_state");
        expect_lit(2, 0, "ovf_cleared");
        // abort in LOAD_REA with a simultaneous step edge
        press(0); press(8'd1); press(8'd2);
        expect_lit(0, 4, "abort_in_rea");
        tick(0, 0, 1, 8'd55);
        tick(0, 0, 0, 8'd55);
        expect_lit(0, 0, "abort_idle");
        expect_lit(1, 0, "abort_led");
        // reset while in COMPUTE, then step held high across reset release
        tick(0, 1, 0, 0);
        press(0); press(8'd1); press(8'd50); press(8'd50); press(8'd100);
        tick(0, 1, 1, 8'd100);
        tick(1, 1, 0, 8'd100);
        tick(1, 1, 1, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 0);
        expect_lit(0, 0, "rst_idle_step_held");
        expect_lit(2, 0, "rst_ovf");
        tick(0, 1, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 0, 0);
        expect_lit(0, 1, "rst_then_edge");
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0,
                 1'($urandom_range(0, 1)), W'($urandom));
        tick(0, 1, 0, 0);
        tick(0, 1, 0, 0);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft_bfly_seq.md
FFT_BFLY_SEQ -- requirements
Module: fft_bfly_seq

Interface
- REQ-001: Parameter DATA_W, default 8, sample and twiddle width in bits; legal range 6..16.
- REQ-002: clock  input  1  single clock; all state updates on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: sw_enable  input  1  run enable; low forces return to IDLE.
- REQ-005: sw_step  input  1  operator step; only its rising edge has effect.
- REQ-006: sw_data  input  DATA_W  operand entry, two's complement; bits [2:0] carry the twiddle index in LOAD_TW.
- REQ-007: led  output  DATA_W  displayed value.
- REQ-008: state_code  output  4  current state encoding.
- REQ-009: ovf  output  1  overflow flag for the current butterfly.

Function
- REQ-010: Step edge detection SHALL be step_q <= sw_step and edge = sw_step & ~step_q; step_q resets to 1, so a step held high through reset produces no edge.
- REQ-011: States and state_code SHALL be: IDLE=0, LOAD_TW=1, LOAD_REB=2, LOAD_IMB=3, LOAD_REA=4, LOAD_IMA=5, COMPUTE=6, SHOW_REY=7, SHOW_IMY=8, SHOW_REZ=9, SHOW_IMZ=10; codes 11..15 are unused.
- REQ-012: Transitions:
  - IDLE -> LOAD_TW on an edge with sw_enable=1.
  - Each LOAD_x captures its operand on an edge and advances in the listed order; LOAD_TW latches sw_data[2:0].
  - LOAD_IMA -> COMPUTE on an edge.
  - COMPUTE -> SHOW_REY unconditionally after exactly 1 cycle.
  - Each SHOW_x advances on an edge; SHOW_IMZ -> LOAD_TW.
- REQ-013: With sw_enable=0, any state SHALL go to IDLE on the next cycle with no capture; this takes priority over a simultaneous edge. Operand registers are retained.
- REQ-014: Twiddle ROM SHALL hold W^k = exp(-j*2*pi*k/8) for k=0..7, scaled to Q1.(DATA_W-1):
  - +1 -> 2^(DATA_W-1)-1
  - -1 -> -2^(DATA_W-1)
  - ±0.7071 -> ±round(0.70711*2^(DATA_W-1)); for DATA_W=8 this is 91 / -91.
- REQ-015: COMPUTE SHALL form (signed):
  - wr = (Rew*Reb - Imw*Imb) >>> (DATA_W-1)
  - wi = (Rew*Imb + Imw*Reb) >>> (DATA_W-1)
  - Products and sums use at least 2*DATA_W+1 bits; the shift is arithmetic and truncating.
- REQ-016: COMPUTE SHALL register Rey=Rea+wr, Imy=Ima+wi, Rez=Rea-wr, Imz=Ima-wi, each evaluated at DATA_W+2 bits and reduced to DATA_W bits per REQ-026.
- REQ-017: ovf SHALL be set in COMPUTE if any of the four sums lies outside the DATA_W signed range; it is cleared on entry to LOAD_TW and otherwise holds.
- REQ-018: led SHALL be a combinational function of state:
  - IDLE and COMPUTE: 0
  - LOAD_x: sw_data
  - SHOW_REY / SHOW_IMY / SHOW_REZ / SHOW_IMZ: Rey / Imy / Rez / Imz respectively.
- REQ-019: Results SHALL remain stable through all SHOW states and are only rewritten in COMPUTE.
- REQ-020: One edge SHALL cause at most one transition; an edge in COMPUTE is ignored.

Reset
- REQ-021: When reset=1 at a clock edge, the following SHALL hold next cycle: state=IDLE, step_q=1, ovf=0, all operand and result registers and the twiddle index = 0.
- REQ-022: Reset asserted mid-sequence, including during COMPUTE, SHALL abandon the sequence with no partial result update.
- REQ-023: Reset SHALL take priority over sw_enable and sw_step.

Configuration
- REQ-024: Macro FFT_BFLY_SAT_EN selects how the four sums are reduced to DATA_W bits.
- REQ-025: With FFT_BFLY_SAT_EN defined, out-of-range sums SHALL clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
- REQ-026: Without FFT_BFLY_SAT_EN, the sums SHALL wrap (keep the low DATA_W bits); ovf behaviour is identical in both builds.

Verification (DATA_W=8)
- REQ-027: Basic W^0 butterfly: tw=0, b=20+0j, a=10+0j, then 4 steps. Required: wr=19; led shows 29, 0, -9, 0; ovf=0.
- REQ-028: W^2 butterfly: tw=2, b=20+0j, a=10+5j. Required: wi=-20; led shows 10, -15, 10, 25; state_code steps 7,8,9,10 then 1.
- REQ-029: Overflow: tw=4, b=-100+0j, a=100+0j. Required with SAT_EN: Rey=127, Rez=0, ovf=1. Required without it: Rey=-56, ovf=1. ovf returns to 0 on the next LOAD_TW.
- REQ-030: Abort: drop sw_enable in LOAD_REA together with a step edge. Required: IDLE next cycle, led=0, no operand captured.
- REQ-031: Reset and edge handling: assert reset in COMPUTE, and separately hold sw_step=1 across reset release. Required: IDLE, ovf=0, results 0, and no transition until sw_step goes low then high with sw_enable=1.
